// File: rtl/head_shift_stream.sv
// head_shift_stream: drops the leading `shift` units of each streamed packet header,
// carrying bits across slice boundaries, and merges key fields into packet metadata.
module head_shift_stream #(
    parameter int HEAD_WIDTH     = 512,
    parameter int UNIT_WIDTH     = 16,
    parameter int HEAD_CANDI_NUM = 16,
    parameter int META_WIDTH     = 256,
    parameter int KEY_NUM        = 4,
    parameter int KEY_WIDTH      = 16,
    parameter int META_CANDI_NUM = 8,
    localparam int HS_W  = (HEAD_CANDI_NUM > 1) ? $clog2(HEAD_CANDI_NUM) : 1,
    localparam int MS_W  = (META_CANDI_NUM > 1) ? $clog2(META_CANDI_NUM) : 1,
    localparam int EXT_W = KEY_NUM * KEY_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_head_valid,
    output logic                  o_head_ready,
    input  logic [HEAD_WIDTH-1:0] i_head_data,
    input  logic                  i_head_start,
    input  logic                  i_head_last,
    input  logic [HS_W-1:0]       i_headShift,
    input  logic [META_WIDTH-1:0] i_meta,
    input  logic [MS_W-1:0]       i_metaOffset,
    input  logic [MS_W-1:0]       i_metaShift,
    input  logic [EXT_W-1:0]      i_extField,
    output logic                  o_head_valid,
    input  logic                  i_head_ready,
    output logic [HEAD_WIDTH-1:0] o_head_data,
    output logic                  o_head_start,
    output logic                  o_head_last,
    output logic [META_WIDTH-1:0] o_meta,
    output logic [MS_W-1:0]       o_metaOffset,
    output logic                  o_metaOvf
);

    // Shift amounts are sized for the largest legal shift so the multiply never wraps.
    localparam int SA_W = $clog2(HEAD_CANDI_NUM * UNIT_WIDTH) + 1;
    localparam int MA_W = $clog2(META_CANDI_NUM * UNIT_WIDTH) + 1;

    typedef enum logic [1:0] {ST_EMPTY, ST_HELD, ST_LAST} state_t;

    state_t                state_q, state_d;
    logic [HEAD_WIDTH-1:0] h_data_q;
    logic                  h_start_q;
    logic [HS_W-1:0]       shift_q;
    logic [META_WIDTH-1:0] pm_meta_q;
    logic [MS_W-1:0]       pm_off_q;
    logic                  pm_ovf_q;
    logic                  ov_q, os_q, ol_q;
    logic [HEAD_WIDTH-1:0] od_q;
    logic [META_WIDTH-1:0] om_q;
    logic [MS_W-1:0]       ooff_q;
    logic                  oovf_q;

    logic                  out_free, head_ready, acc;
    logic                  emit, emit_last;
    logic [SA_W-1:0]       sh_amt;
    logic [2*HEAD_WIDTH-1:0] cat_in;
    logic [HEAD_WIDTH-1:0] shifted;
    logic [MA_W-1:0]       meta_amt;
    logic [META_WIDTH-1:0] ext_al, merged;
    logic [MS_W:0]         off_sum;
    logic                  off_ovf;
    logic [MS_W-1:0]       off_new;

    assign out_free   = !ov_q || i_head_ready;
    assign head_ready = i_rst_n && ((state_q == ST_EMPTY) || out_free);
    assign acc        = i_head_valid && head_ready;

    // Held slice joined with the incoming slice (or zeros when flushing), then shifted.
    assign sh_amt  = SA_W'(shift_q) * SA_W'(UNIT_WIDTH);
    assign cat_in  = {h_data_q, emit_last ? {HEAD_WIDTH{1'b0}} : i_head_data};
    assign shifted = HEAD_WIDTH'((cat_in << sh_amt) >> HEAD_WIDTH);

    // Key fields are left-aligned, then moved down by the current metadata offset.
    assign meta_amt = MA_W'(i_metaOffset) * MA_W'(UNIT_WIDTH);
    assign ext_al   = META_WIDTH'(i_extField) << (META_WIDTH - EXT_W);
    assign merged   = i_meta | (ext_al >> meta_amt);

    assign off_sum  = {1'b0, i_metaOffset} + {1'b0, i_metaShift};
    assign off_ovf  = off_sum >= (MS_W+1)'(META_CANDI_NUM);
    assign off_new  = off_ovf ? MS_W'(META_CANDI_NUM - 1) : off_sum[MS_W-1:0];

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state_q <= ST_EMPTY;
        else          state_q <= state_d;
    end

    // Next state: an accepted beat always becomes the held slice; LAST drains when the output is free.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY, ST_HELD: if (acc) state_d = i_head_last ? ST_LAST : ST_HELD;
            ST_LAST: if (out_free) state_d = acc ? (i_head_last ? ST_LAST : ST_HELD) : ST_EMPTY;
            default: state_d = ST_EMPTY;
        endcase
    end

    // Emission: HELD emits when a beat arrives (a start beat there aborts and flushes); LAST flushes.
    always_comb begin
        emit      = 1'b0;
        emit_last = 1'b0;
        case (state_q)
            ST_HELD: begin
                emit      = acc;
                emit_last = acc && i_head_start;
            end
            ST_LAST: begin
                emit      = out_free;
                emit_last = out_free;
            end
            default: ;
        endcase
    end

    // Hold register, per-packet context, and output registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            h_data_q  <= '0;
            h_start_q <= 1'b0;
            shift_q   <= '0;
            pm_meta_q <= '0;
            pm_off_q  <= '0;
            pm_ovf_q  <= 1'b0;
            ov_q      <= 1'b0;
            od_q      <= '0;
            os_q      <= 1'b0;
            ol_q      <= 1'b0;
            om_q      <= '0;
            ooff_q    <= '0;
            oovf_q    <= 1'b0;
        end else begin
            if (acc) begin
                h_data_q  <= i_head_data;
                h_start_q <= i_head_start;
                if (i_head_start) begin
                    shift_q   <= i_headShift;
                    pm_meta_q <= merged;
                    pm_off_q  <= off_new;
                    pm_ovf_q  <= off_ovf;
                end
            end
            if (emit) begin
                ov_q <= 1'b1;
                od_q <= shifted;
                os_q <= h_start_q;
                ol_q <= emit_last;
                // Metadata of the packet being emitted; a new start accepted now updates pm_* only.
                if (h_start_q) begin
                    om_q   <= pm_meta_q;
                    ooff_q <= pm_off_q;
                    oovf_q <= pm_ovf_q;
                end
            end else if (out_free) begin
                ov_q <= 1'b0;
            end
        end
    end

    assign o_head_ready = head_ready;
    assign o_head_valid = ov_q;
    assign o_head_data  = od_q;
    assign o_head_start = os_q;
    assign o_head_last  = ol_q;
    assign o_meta       = om_q;
    assign o_metaOffset = ooff_q;
    assign o_metaOvf    = oovf_q;

endmodule

// File: tb/tb_head_shift_stream.sv
// tb_head_shift_stream: directed and randomized checks against a unit-level packet model.
module tb_head_shift_stream;

    localparam int HW = 64, UW = 8, HCN = 8, MW = 64, KN = 2, KW = 8, MCN = 8;

    logic          i_clk, i_rst_n;
    logic          i_head_valid, o_head_ready;
    logic [63:0]   i_head_data;
    logic          i_head_start, i_head_last;
    logic [2:0]    i_headShift;
    logic [63:0]   i_meta;
    logic [2:0]    i_metaOffset, i_metaShift;
    logic [15:0]   i_extField;
    logic          o_head_valid, i_head_ready;
    logic [63:0]   o_head_data;
    logic          o_head_start, o_head_last;
    logic [63:0]   o_meta;
    logic [2:0]    o_metaOffset;
    logic          o_metaOvf;

    head_shift_stream #(
        .HEAD_WIDTH(HW), .UNIT_WIDTH(UW), .HEAD_CANDI_NUM(HCN), .META_WIDTH(MW),
        .KEY_NUM(KN), .KEY_WIDTH(KW), .META_CANDI_NUM(MCN)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_head_valid(i_head_valid), .o_head_ready(o_head_ready),
        .i_head_data(i_head_data), .i_head_start(i_head_start), .i_head_last(i_head_last),
        .i_headShift(i_headShift), .i_meta(i_meta), .i_metaOffset(i_metaOffset),
        .i_metaShift(i_metaShift), .i_extField(i_extField),
        .o_head_valid(o_head_valid), .i_head_ready(i_head_ready),
        .o_head_data(o_head_data), .o_head_start(o_head_start), .o_head_last(o_head_last),
        .o_meta(o_meta), .o_metaOffset(o_metaOffset), .o_metaOvf(o_metaOvf)
    );

    typedef struct {
        logic [63:0] data; logic st, lst; logic [2:0] hs;
        logic [63:0] meta; logic [2:0] off, msh; logic [15:0] ext;
    } in_t;
    typedef struct {
        logic [63:0] data; logic st, lst; logic [63:0] meta; logic [2:0] off; logic ovf;
    } exp_t;

    in_t         inq[$];
    exp_t        expq[$];
    logic [63:0] pkt[$];
    int          n_chk = 0, n_err = 0;
    int          rdy_low = 0;
    bit          rnd_rdy = 0, full = 1;
    bit [1:0]    lat_pipe = '0;

    initial begin
        i_clk = 0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Reference: the packet as a unit stream, first s units removed, zeros appended, re-sliced.
    task automatic model(input int s, input logic [63:0] meta, input logic [15:0] ext,
                         input int off, input int msh);
        logic [7:0]  u[$];
        logic [63:0] w, m;
        exp_t        e;
        int          n, pos, sum;
        n = pkt.size();
        for (int i = 0; i < n; i++) begin
            w = pkt[i];
            for (int b = 7; b >= 0; b--) u.push_back(w[b*8 +: 8]);
        end
        for (int k = 0; k < s; k++) begin
            void'(u.pop_front());
            u.push_back(8'h00);
        end
        m = meta;
        for (int b = 0; b < 16; b++) begin
            pos = 63 - off*8 - b;
            if (pos >= 0 && ext[15-b]) m[pos] = 1'b1;
        end
        sum = off + msh;
        for (int i = 0; i < n; i++) begin
            e.data = '0;
            for (int j = 0; j < 8; j++) e.data = {e.data[55:0], u[i*8+j]};
            e.st = (i == 0); e.lst = (i == n-1); e.meta = m;
            e.off = (sum >= 8) ? 3'd7 : 3'(sum); e.ovf = (sum >= 8);
            expq.push_back(e);
        end
    endtask

    task automatic send(input int s, input logic [63:0] meta, input logic [15:0] ext,
                        input int off, input int msh, input bit abort, input bit use_model);
        in_t b;
        for (int i = 0; i < pkt.size(); i++) begin
            b.data = pkt[i]; b.st = (i == 0); b.lst = (i == pkt.size()-1) && !abort;
            if (i == 0) begin
                b.hs = 3'(s); b.meta = meta; b.ext = ext; b.off = 3'(off); b.msh = 3'(msh);
            end else begin
                b.hs = 3'($urandom); b.meta = {$urandom, $urandom}; b.ext = 16'($urandom);
                b.off = 3'($urandom); b.msh = 3'($urandom);
            end
            inq.push_back(b);
        end
        if (use_model) model(s, meta, ext, off, msh);
    endtask

    task automatic push_exp(input logic [63:0] d, input logic st, input logic lst,
                            input logic [63:0] m, input logic [2:0] off, input logic ovf);
        exp_t e;
        e.data = d; e.st = st; e.lst = lst; e.meta = m; e.off = off; e.ovf = ovf;
        expq.push_back(e);
    endtask

    task automatic rand_pkt(input bit allow_abort);
        int n;
        bit ab;
        n = $urandom_range(1, 4);
        pkt.delete();
        for (int i = 0; i < n; i++) pkt.push_back({$urandom, $urandom});
        ab = allow_abort && ($urandom_range(0, 9) == 0);
        send($urandom_range(0, 7), {$urandom, $urandom}, 16'($urandom),
             $urandom_range(0, 7), $urandom_range(0, 7), ab, 1);
    endtask

    // One cycle: drive at negedge, observe after settling, account for handshakes at the next posedge.
    task automatic step();
        bit acc_last;
        @(negedge i_clk);
        if (rdy_low > 0) begin i_head_ready = 0; rdy_low--; end
        else if (rnd_rdy) i_head_ready = ($urandom_range(0, 2) != 0);
        else i_head_ready = 1;
        if (inq.size() > 0 && (full || $urandom_range(0, 3) != 0)) begin
            i_head_valid = 1; i_head_data = inq[0].data;
            i_head_start = inq[0].st; i_head_last = inq[0].lst; i_headShift = inq[0].hs;
            i_meta = inq[0].meta; i_metaOffset = inq[0].off; i_metaShift = inq[0].msh;
            i_extField = inq[0].ext;
        end else begin
            i_head_valid = 0;
        end
        #1;
        if (lat_pipe[1]) chk("lat_last", {o_head_valid, o_head_last}, 2'b11);
        if (full && i_head_valid) chk("fullrate", o_head_ready, 1);
        if (o_head_valid && i_head_ready) begin
            if (expq.size() == 0) chk("extra_beat", 1, 0);
            else begin
                chk("data", o_head_data, expq[0].data);
                chk("start", o_head_start, expq[0].st);
                chk("last", o_head_last, expq[0].lst);
                chk("meta", o_meta, expq[0].meta);
                chk("moff", o_metaOffset, expq[0].off);
                chk("movf", o_metaOvf, expq[0].ovf);
                void'(expq.pop_front());
            end
        end else if (o_head_valid && expq.size() > 0) begin
            chk("stall_data", o_head_data, expq[0].data);
        end
        acc_last = 0;
        if (i_head_valid && o_head_ready) begin
            acc_last = full && inq[0].lst;
            void'(inq.pop_front());
        end
        lat_pipe = {lat_pipe[0], acc_last};
    endtask

    task automatic drain(input int budget);
        int c;
        c = 0;
        while ((inq.size() > 0 || expq.size() > 0) && c < budget) begin
            step();
            c++;
        end
        chk("drain_left", 64'(inq.size() + expq.size()), 0);
    endtask

    initial begin
        i_rst_n = 0; i_head_valid = 0; i_head_ready = 1; i_head_data = '0;
        i_head_start = 0; i_head_last = 0; i_headShift = '0; i_meta = '0;
        i_metaOffset = '0; i_metaShift = '0; i_extField = '0;
        repeat (3) @(negedge i_clk);
        #1;
        chk("rst_ready", o_head_ready, 0);
        chk("rst_valid", o_head_valid, 0);
        chk("rst_data", o_head_data, 0);
        chk("rst_flags", {o_head_start, o_head_last, o_metaOvf}, 0);
        chk("rst_meta", o_meta, 0);
        chk("rst_moff", o_metaOffset, 0);
        i_rst_n = 1;

        // Two-slice pass-through, two-slice shift by 3, single-slice shift by 1 back-to-back.
        full = 1; rnd_rdy = 0;
        pkt = '{64'h0011223344556677, 64'h8899AABBCCDDEEFF};
        send(0, 64'h0, 16'h0, 0, 0, 0, 0);
        push_exp(64'h0011223344556677, 1, 0, 64'h0, 3'd0, 0);
        push_exp(64'h8899AABBCCDDEEFF, 0, 1, 64'h0, 3'd0, 0);
        send(3, 64'h0, 16'h0, 0, 0, 0, 0);
        push_exp(64'h33445566778899AA, 1, 0, 64'h0, 3'd0, 0);
        push_exp(64'hBBCCDDEEFF000000, 0, 1, 64'h0, 3'd0, 0);
        pkt = '{64'h0102030405060708};
        send(1, 64'h0, 16'h0, 0, 0, 0, 0);
        push_exp(64'h0203040506070800, 1, 1, 64'h0, 3'd0, 0);
        send(1, 64'h0, 16'h0, 0, 0, 0, 0);
        push_exp(64'h0203040506070800, 1, 1, 64'h0, 3'd0, 0);
        drain(100);

        // Metadata merge, then offset saturation.
        pkt = '{64'h1122334455667788};
        send(0, 64'h0, 16'hABCD, 2, 3, 0, 0);
        push_exp(64'h1122334455667788, 1, 1, 64'h0000ABCD00000000, 3'd5, 0);
        send(0, 64'h0, 16'hABCD, 2, 7, 0, 0);
        push_exp(64'h1122334455667788, 1, 1, 64'h0000ABCD00000000, 3'd7, 1);
        drain(100);

        // Backpressure: output stalled for 5 cycles mid-packet.
        full = 0;
        pkt = '{{$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}};
        send(5, {$urandom, $urandom}, 16'h1234, 1, 2, 0, 1);
        step(); step(); step();
        rdy_low = 5;
        drain(200);

        // Abort: a start beat while a packet is still open.
        full = 1;
        pkt = '{64'hA0A1A2A3A4A5A6A7, 64'hB0B1B2B3B4B5B6B7};
        send(2, 64'hF0, 16'h5A5A, 0, 1, 1, 1);
        pkt = '{64'hC0C1C2C3C4C5C6C7, 64'hD0D1D2D3D4D5D6D7};
        send(4, 64'h0F00, 16'hA5A5, 3, 2, 0, 1);
        drain(100);

        // Reset during slice 2 of 3; the partial packet is dropped.
        pkt = '{64'h1, 64'h2, 64'h3};
        send(1, 64'h0, 16'h0, 0, 0, 0, 0);
        step();
        @(negedge i_clk);
        i_rst_n = 0;
        i_head_valid = 1; i_head_data = inq[0].data; i_head_start = 0; i_head_last = 0;
        #1;
        chk("rst_mid_ready", o_head_ready, 0);
        @(negedge i_clk);
        #1;
        chk("rst_mid_valid", o_head_valid, 0);
        chk("rst_mid_meta", o_meta, 0);
        i_rst_n = 1; i_head_valid = 0;
        inq.delete(); lat_pipe = '0;
        pkt = '{64'h0123456789ABCDEF, 64'hFEDCBA9876543210};
        send(6, 64'h8000000000000001, 16'hBEEF, 4, 4, 0, 1);
        drain(100);

        // Random traffic with random backpressure and valid gaps.
        full = 0; rnd_rdy = 1;
        for (int i = 0; i < 100; i++) rand_pkt(i < 99);
        drain(5000);

        // Full rate, back-to-back packets, ready held high.
        full = 1; rnd_rdy = 0;
        for (int i = 0; i < 20; i++) rand_pkt(0);
        drain(500);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
